rojo_io_hub: RTL and testbench

- Synthesizable multi-channel port peripheral on the RojoBlaze I/O bus.
- Decodes port_id/write_strobe/read_strobe into NUM_CH channels; each channel has a TX FIFO (processor->external) and an RX FIFO (external->processor), both with valid/ready handshakes.
- Drives in_port and the interrupt/interrupt_ack handshake.
- Parametrised in data width, address width, channel count and FIFO depth.

---
 rtl/rojo_io_hub.sv | 167 ++++++++++++++++
 tb/tb_rojo_io_hub.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rojo_io_hub.sv
// Multi-channel RojoBlaze I/O peripheral: per-channel TX/RX FIFOs, status registers and interrupt handshake.
// Optional internal TX->RX loopback per channel when ROJO_IO_LOOPBACK_EN is defined.
module rojo_io_hub #(
  parameter int unsigned PORT_WIDTH = 8,
  parameter int unsigned PORT_DEPTH = 8,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [PORT_DEPTH-1:0]        port_id,
  input  logic                         write_strobe,
  input  logic                         read_strobe,
  input  logic [PORT_WIDTH-1:0]        out_port,
  output logic [PORT_WIDTH-1:0]        in_port,
  output logic                         interrupt,
  input  logic                         interrupt_ack,
  output logic [NUM_CH*PORT_WIDTH-1:0] tx_data,
  output logic [NUM_CH-1:0]            tx_valid,
  input  logic [NUM_CH-1:0]            tx_ready,
  input  logic [NUM_CH*PORT_WIDTH-1:0] rx_data,
  input  logic [NUM_CH-1:0]            rx_valid,
  output logic [NUM_CH-1:0]            rx_ready
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IRQ_IDLE     = 2'd0,
    IRQ_ASSERT   = 2'd1,
    IRQ_WAIT_CLR = 2'd2
  } irq_state_e;

  logic [PORT_WIDTH-1:0] ch_rd_data [NUM_CH];
  logic [PORT_WIDTH-1:0] ch_rd_stat [NUM_CH];
  logic [NUM_CH-1:0]     ch_pend;
  logic [PORT_WIDTH-1:0] rd_mux;
  logic                  pend;
  irq_state_e            state, state_nxt;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [PORT_DEPTH-1:0] DATA_ADDR = PORT_DEPTH'(2 * c);
    localparam logic [PORT_DEPTH-1:0] STAT_ADDR = PORT_DEPTH'(2 * c + 1);

    logic [PORT_WIDTH-1:0] tx_mem [FIFO_DEPTH];
    logic [PORT_WIDTH-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]         tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic [CW-1:0]         tx_cnt, rx_cnt;
    logic [PORT_WIDTH-1:0] tx_head, rx_head, rx_in;
    logic                  tx_empty, tx_full, rx_empty, rx_full;
    logic                  sel_data, sel_stat, wr_data, wr_stat;
    logic                  tx_push, tx_pop, rx_push, rx_pop, lb_xfer;
    logic                  tx_ovf_q, irq_en_q, lb_en_q;

    assign sel_data = (port_id == DATA_ADDR);
    assign sel_stat = (port_id == STAT_ADDR);
    assign wr_data  = write_strobe & sel_data;
    assign wr_stat  = write_strobe & sel_stat;

    assign tx_empty = (tx_cnt == '0);
    assign tx_full  = (tx_cnt == CW'(FIFO_DEPTH));
    assign rx_empty = (rx_cnt == '0);
    assign rx_full  = (rx_cnt == CW'(FIFO_DEPTH));
    assign tx_head  = tx_mem[tx_rd_ptr];
    assign rx_head  = rx_mem[rx_rd_ptr];

    // In loopback the TX head moves straight into RX and the external side is fenced off
    assign lb_xfer = lb_en_q & ~tx_empty & ~rx_full;
    assign tx_pop  = lb_en_q ? lb_xfer : (~tx_empty & tx_ready[c]);
    assign tx_push = wr_data & (~tx_full | tx_pop);
    assign rx_push = lb_en_q ? lb_xfer : (rx_valid[c] & ~rx_full);
    assign rx_pop  = read_strobe & sel_data & ~rx_empty;
    assign rx_in   = lb_en_q ? tx_head : rx_data[c*PORT_WIDTH +: PORT_WIDTH];

    always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= out_port;
      if (rx_push) rx_mem[rx_wr_ptr] <= rx_in;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        tx_wr_ptr <= '0;
        tx_rd_ptr <= '0;
        tx_cnt    <= '0;
        rx_wr_ptr <= '0;
        rx_rd_ptr <= '0;
        rx_cnt    <= '0;
        tx_ovf_q  <= 1'b0;
        irq_en_q  <= 1'b0;
      end else begin
        if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
        if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
        if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
        if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
        case ({tx_push, tx_pop})
          2'b10:   tx_cnt <= tx_cnt + CW'(1);
          2'b01:   tx_cnt <= tx_cnt - CW'(1);
          default: tx_cnt <= tx_cnt;
        endcase
        case ({rx_push, rx_pop})
          2'b10:   rx_cnt <= rx_cnt + CW'(1);
          2'b01:   rx_cnt <= rx_cnt - CW'(1);
          default: rx_cnt <= rx_cnt;
        endcase
        if (wr_data & ~tx_push)          tx_ovf_q <= 1'b1;
        else if (wr_stat & out_port[1])  tx_ovf_q <= 1'b0;
        if (wr_stat) irq_en_q <= out_port[0];
      end
    end

`ifdef ROJO_IO_LOOPBACK_EN
    always_ff @(posedge clk) begin
      if (reset)        lb_en_q <= 1'b0;
      else if (wr_stat) lb_en_q <= out_port[2];
    end
`else
    assign lb_en_q = 1'b0;
`endif

    assign tx_data[c*PORT_WIDTH +: PORT_WIDTH] = tx_head;
    assign tx_valid[c] = ~tx_empty & ~lb_en_q;
    assign rx_ready[c] = ~rx_full & ~lb_en_q;
    assign ch_pend[c]  = irq_en_q & ~rx_empty;
    assign ch_rd_data[c] = rx_empty ? '0 : rx_head;
    assign ch_rd_stat[c] = PORT_WIDTH'({lb_en_q, irq_en_q, tx_ovf_q, tx_full, tx_empty,
                                        rx_full, rx_empty});
  end

  // Read mux: unmapped addresses fall through to zero
  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (port_id == PORT_DEPTH'(2 * i))          rd_mux = ch_rd_data[i];
      else if (port_id == PORT_DEPTH'(2 * i + 1)) rd_mux = ch_rd_stat[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) in_port <= '0;
    else       in_port <= rd_mux;
  end

  assign pend = |ch_pend;

  always_ff @(posedge clk) begin
    if (reset) state <= IRQ_IDLE;
    else       state <= state_nxt;
  end

  // Once acknowledged, hold off until every enabled RX FIFO has drained
  always_comb begin
    state_nxt = state;
    case (state)
      IRQ_IDLE:     if (pend)          state_nxt = IRQ_ASSERT;
      IRQ_ASSERT:   if (interrupt_ack) state_nxt = IRQ_WAIT_CLR;
      IRQ_WAIT_CLR: if (!pend)         state_nxt = IRQ_IDLE;
      default:                         state_nxt = IRQ_IDLE;
    endcase
  end

  always_comb begin
    interrupt = 1'b0;
    if (state == IRQ_ASSERT) interrupt = 1'b1;
  end

endmodule

// File: tb/tb_rojo_io_hub.sv
// Scoreboard bench for rojo_io_hub: expected reads and TX transfers are queued by the driver
// and popped by a monitor at the falling edge whenever the DUT presents them.
module tb_rojo_io_hub;
  localparam int unsigned PW = 8;
  localparam int unsigned PD = 8;
  localparam int unsigned NC = 4;
  localparam int unsigned FD = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [PD-1:0]  port_id;
  logic           write_strobe, read_strobe;
  logic [PW-1:0]  out_port;
  logic [PW-1:0]  in_port;
  logic           interrupt, interrupt_ack;
  logic [NC*PW-1:0] tx_data, rx_data;
  logic [NC-1:0]  tx_valid, tx_ready, rx_valid, rx_ready;

  rojo_io_hub #(.PORT_WIDTH(PW), .PORT_DEPTH(PD), .NUM_CH(NC), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .port_id(port_id), .write_strobe(write_strobe),
    .read_strobe(read_strobe), .out_port(out_port), .in_port(in_port),
    .interrupt(interrupt), .interrupt_ack(interrupt_ack), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] d;
  } tx_exp_t;

  tx_exp_t    exp_tx[$];
  logic [7:0] exp_rd[$];
  string      exp_rd_nm[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic       mon_rd = 1'b0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares registered read data one cycle after a read, and every TX handshake
  task automatic monitor();
    logic    rd_q;
    tx_exp_t e;
    string   nm;
    rd_q = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_q) begin
        if (exp_rd.size() == 0) begin
          check("rd_unexpected", 32'd1, 32'd0);
        end else begin
          nm = exp_rd_nm.pop_front();
          check(nm, 32'(in_port), 32'(exp_rd.pop_front()));
        end
      end
      rd_q = mon_rd;
      for (int c = 0; c < int'(NC); c++) begin
        if (tx_valid[c] && tx_ready[c]) begin
          if (exp_tx.size() == 0) begin
            check("tx_unexpected", 32'(tx_data[c*8 +: 8]), 32'hFFFF_FFFF);
          end else begin
            e = exp_tx.pop_front();
            check("tx_ch", 32'(c), 32'(e.ch));
            check("tx_data", 32'(tx_data[c*8 +: 8]), 32'(e.d));
          end
        end
      end
    end
  endtask

  task automatic cyc(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [7:0] p, logic [7:0] d);
    port_id = p; out_port = d; write_strobe = 1'b1;
    cyc();
    write_strobe = 1'b0;
  endtask

  task automatic rd(logic [7:0] p, logic [7:0] e, logic pop, string nm);
    port_id = p; read_strobe = pop; mon_rd = 1'b1;
    exp_rd.push_back(e);
    exp_rd_nm.push_back(nm);
    cyc();
    read_strobe = 1'b0; mon_rd = 1'b0;
  endtask

  task automatic wr_tx(logic [1:0] ch, logic [7:0] d);
    tx_exp_t e;
    e.ch = ch; e.d = d;
    exp_tx.push_back(e);
    wr(8'({ch, 1'b0}), d);
  endtask

  task automatic wait_drain(int max);
    for (int i = 0; i < max && exp_tx.size() != 0; i++) cyc();
    check("tx_drain", 32'(exp_tx.size()), 32'd0);
  endtask

  task automatic wait_irq(logic v, int max, string nm);
    for (int i = 0; i < max && interrupt !== v; i++) cyc();
    check(nm, 32'(interrupt), 32'(v));
  endtask

  task automatic rx_push(int ch, logic [7:0] d);
    rx_data[ch*8 +: 8] = d; rx_valid[ch] = 1'b1;
    cyc();
    rx_valid[ch] = 1'b0;
  endtask

  initial begin
    reset = 1'b1; port_id = '0; write_strobe = 1'b0; read_strobe = 1'b0;
    out_port = '0; interrupt_ack = 1'b0; tx_ready = '0; rx_data = '0; rx_valid = '0;
    fork
      monitor();
    join_none
    cyc(3);
    reset = 1'b0;

    // reset state
    check("rst_in_port", 32'(in_port), 32'h0);
    check("rst_irq", 32'(interrupt), 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_rx_ready", 32'(rx_ready), 32'hF);
    rd(8'd1, 8'h05, 1'b0, "status_ch0_reset");

    // ch1 TX ordering with backpressure
    wr_tx(2'd1, 8'hA5);
    wr_tx(2'd1, 8'h3C);
    check("tx1_valid", 32'(tx_valid[1]), 32'h1);
    check("tx1_head", 32'(tx_data[15:8]), 32'hA5);
    tx_ready[1] = 1'b1;
    wait_drain(10);
    check("tx1_empty", 32'(tx_valid[1]), 32'h0);
    tx_ready[1] = 1'b0;

    // ch0 overflow, sticky flag, clear, and full-plus-pop acceptance
    for (int i = 0; i < 9; i++) begin
      if (i < 8) wr_tx(2'd0, 8'(8'h10 + i));
      else       wr(8'd0, 8'h18);
    end
    rd(8'd1, 8'h19, 1'b0, "status_ch0_ovf");
    wr(8'd1, 8'h02);
    rd(8'd1, 8'h09, 1'b0, "status_ch0_ovf_clr");
    tx_ready[0] = 1'b1;
    wr_tx(2'd0, 8'h99);
    wait_drain(20);
    tx_ready[0] = 1'b0;
    rd(8'd1, 8'h05, 1'b0, "status_ch0_drained");

    // interrupt on ch2
    wr(8'd5, 8'h01);
    rx_push(2, 8'h77);
    wait_irq(1'b1, 4, "irq_raise");
    interrupt_ack = 1'b1;
    cyc();
    interrupt_ack = 1'b0;
    check("irq_ack_drop", 32'(interrupt), 32'h0);
    cyc(3);
    check("irq_no_refire", 32'(interrupt), 32'h0);
    rd(8'd4, 8'h77, 1'b1, "rx2_data");
    cyc(2);
    rx_push(2, 8'h88);
    wait_irq(1'b1, 4, "irq_reraise");
    wr(8'd5, 8'h00);
    cyc(2);
    check("irq_hold_without_ack", 32'(interrupt), 32'h1);
    interrupt_ack = 1'b1;
    cyc();
    interrupt_ack = 1'b0;
    check("irq_ack2_drop", 32'(interrupt), 32'h0);
    rd(8'd4, 8'h88, 1'b1, "rx2_data2");
    rd(8'd5, 8'h05, 1'b0, "status_ch2");
    cyc(2);
    check("irq_idle", 32'(interrupt), 32'h0);

    // ch3 RX fill, pop at full with source waiting, push+pop at count 7
    for (int i = 0; i < 8; i++) rx_push(3, 8'(8'h30 + i));
    check("rx3_full_ready", 32'(rx_ready), 32'h7);
    rd(8'd7, 8'h06, 1'b0, "status_ch3_full");
    rx_data[31:24] = 8'h38; rx_valid[3] = 1'b1;
    rd(8'd6, 8'h30, 1'b1, "rx3_pop_full");
    cyc();
    rx_valid[3] = 1'b0;
    rd(8'd7, 8'h06, 1'b0, "status_ch3_refull");
    rd(8'd6, 8'h31, 1'b1, "rx3_pop1");
    rx_data[31:24] = 8'h39; rx_valid[3] = 1'b1;
    rd(8'd6, 8'h32, 1'b1, "rx3_pushpop");
    rx_valid[3] = 1'b0;
    check("rx3_ready_7", 32'(rx_ready), 32'hF);
    rd(8'd7, 8'h04, 1'b0, "status_ch3_7");
    for (int i = 3; i < 10; i++) rd(8'd6, 8'(8'h30 + i), 1'b1, "rx3_drain");
    rd(8'd7, 8'h05, 1'b0, "status_ch3_empty");
    rd(8'd6, 8'h00, 1'b1, "rx3_empty_pop");

    // unmapped addresses
    rd(8'd8, 8'h00, 1'b1, "unmapped_8");
    wr(8'd8, 8'h12);
    wr(8'd9, 8'hFF);
    check("unmapped_wr_tx", 32'(tx_valid), 32'h0);
    rd(8'd255, 8'h00, 1'b0, "unmapped_255");
    rd(8'd1, 8'h05, 1'b0, "status_ch0_after_unmapped");

`ifdef ROJO_IO_LOOPBACK_EN
    wr(8'd1, 8'h04);
    check("lb_rx_ready", 32'(rx_ready), 32'hE);
    wr(8'd0, 8'h5A);
    check("lb_tx_valid0", 32'(tx_valid), 32'h0);
    cyc();
    check("lb_tx_valid1", 32'(tx_valid), 32'h0);
    rd(8'd1, 8'h44, 1'b0, "lb_status");
    rd(8'd0, 8'h5A, 1'b1, "lb_data");
    rd(8'd1, 8'h45, 1'b0, "lb_status_empty");
    check("lb_tx_valid2", 32'(tx_valid), 32'h0);
    wr(8'd1, 8'h00);
`else
    wr(8'd1, 8'h04);
    rd(8'd1, 8'h05, 1'b0, "nolb_status");
    check("nolb_rx_ready", 32'(rx_ready), 32'hF);
    wr_tx(2'd0, 8'h5A);
    check("nolb_tx_valid", 32'(tx_valid), 32'h1);
    tx_ready[0] = 1'b1;
    wait_drain(10);
    tx_ready[0] = 1'b0;
`endif

    // reset mid-transfer and mid-interrupt
    wr(8'd2, 8'h11);
    wr(8'd5, 8'h01);
    rx_push(2, 8'h44);
    wait_irq(1'b1, 4, "irq_before_reset");
    check("tx_before_reset", 32'(tx_valid), 32'h2);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rst2_tx_valid", 32'(tx_valid), 32'h0);
    check("rst2_rx_ready", 32'(rx_ready), 32'hF);
    check("rst2_irq", 32'(interrupt), 32'h0);
    check("rst2_in_port", 32'(in_port), 32'h0);
    rd(8'd5, 8'h05, 1'b0, "rst2_status_ch2");
    rd(8'd3, 8'h05, 1'b0, "rst2_status_ch1");
    cyc(2);
    check("rst2_irq_idle", 32'(interrupt), 32'h0);

    cyc(3);
    check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
